// File: rtl/bit_index_pkg.sv
// Shared types and sizing helpers for the bit-index serializer.
package bit_index_pkg;

  // Controller states: IDLE waits for a vector, EMIT streams its set-bit indices.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index width for an n-bit vector: $clog2(n), never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_index_serializer_if.sv
// Bundle of the upstream vector handshake and downstream index handshake.
//
// Handshake rules (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds its payload steady
// while valid is high and ready is low; ready may depend combinationally on
// the sink state and on the downstream ready, never on the same-side valid.
interface bit_index_serializer_if #(
  parameter int N = 8
);
  localparam int IW = bit_index_pkg::idx_width(N);

  logic [N-1:0]  I_VECTOR;
  logic          I_VALID;
  logic          I_MSB_FIRST;
  logic          O_READY;
  logic [IW-1:0] O_INDEX;
  logic          O_VALID;
  logic          I_READY;
  logic          O_LAST;
  logic [IW:0]   O_COUNT;
  logic          O_DONE;

  // Environment side: offers vectors, consumes indices.
  modport master (
    output I_VECTOR, I_VALID, I_MSB_FIRST, I_READY,
    input  O_READY, O_INDEX, O_VALID, O_LAST, O_COUNT, O_DONE
  );

  // Serializer side.
  modport slave (
    input  I_VECTOR, I_VALID, I_MSB_FIRST, I_READY,
    output O_READY, O_INDEX, O_VALID, O_LAST, O_COUNT, O_DONE
  );

endinterface

// File: rtl/bit_index_serializer_prio_enc.sv
// Directional priority encoder: lowest set index when msb_first = 0,
// highest set index when msb_first = 1. idx is 0 when vec is all zero.
module prio_enc
  import bit_index_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  vec,
  input  logic          msb_first,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan so that the winning bit is the last one written; idx only ever
  // takes values below N, so non-power-of-two widths stay in range.
  always_comb begin
    idx = '0;
    any = |vec;
    if (msb_first) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = IW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bit_index_serializer.sv
// Serializes the indices of the set bits of an accepted vector, one index per
// cycle, in ascending or descending order, with back-to-back vector loading.
module bit_index_serializer
  import bit_index_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  bit_index_serializer_if.slave        bus,
  output state_t                       dbg_state
);

  localparam int IW = idx_width(N);

  state_t        state_q, state_d;
  logic [N-1:0]  r_vec, vec_d;
  logic          r_dir, dir_d;
  logic [IW:0]   r_count, count_d;
  logic          r_done, done_d;

  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic [IW:0]   pop;
  logic          emit;
  logic          o_valid;
  logic          o_last;
  logic          o_ready;
  logic          in_hs;
  logic          out_hs;

  // Search the remaining bits for the next index in the latched direction.
  prio_enc #(.N(N)) u_prio_enc (
    .vec       (r_vec),
    .msb_first (r_dir),
    .idx       (enc_idx),
    .any       (enc_any)
  );

  // Popcount of the offered vector, captured into O_COUNT on accept.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (IW+1)'(bus.I_VECTOR[i]);
    end
  end

  // Output-side decode: the current index is combinational from r_vec, and
  // O_LAST marks the single remaining set bit.
  always_comb begin
    emit    = (state_q == EMIT);
    o_valid = emit && enc_any;
    o_last  = o_valid && ((r_vec & (r_vec - N'(1))) == '0);
    // Ready in IDLE, or while the final beat is being taken so the next
    // vector loads without a bubble.
    o_ready = !rst && (!emit || (o_valid && o_last && bus.I_READY));
    in_hs   = bus.I_VALID && o_ready;
    out_hs  = o_valid && bus.I_READY;
  end

  // Next-state and datapath update; a load takes precedence over clearing
  // the consumed bit because the old vector is finished in that cycle.
  always_comb begin
    state_d = state_q;
    vec_d   = r_vec;
    dir_d   = r_dir;
    count_d = r_count;
    done_d  = 1'b0;
    if (in_hs) begin
      vec_d   = bus.I_VECTOR;
      dir_d   = bus.I_MSB_FIRST;
      count_d = pop;
      state_d = (bus.I_VECTOR != '0) ? EMIT : IDLE;
      done_d  = (bus.I_VECTOR == '0) || (out_hs && o_last);
    end else if (out_hs) begin
      vec_d[enc_idx] = 1'b0;
      if (o_last) state_d = IDLE;
      done_d = o_last;
    end
  end

  // State and datapath registers with synchronous reset; a reset mid-vector
  // simply drops the remaining bits without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_vec   <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_vec   <= vec_d;
      r_dir   <= dir_d;
      r_count <= count_d;
      r_done  <= done_d;
    end
  end

  // Drive the bundle outputs and the state debug tap.
  always_comb begin
    bus.O_READY = o_ready;
    bus.O_VALID = o_valid;
    bus.O_INDEX = o_valid ? enc_idx : '0;
    bus.O_LAST  = o_last;
    bus.O_COUNT = r_count;
    bus.O_DONE  = r_done;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed bench for bit_index_serializer at N = 8, 16 and 5.
module tb_bit_index_serializer;
  import bit_index_pkg::*;

  logic clk;
  logic rst;

  // Shared drivers, routed to the instance selected by sel.
  int          sel;
  int          cur_n;
  logic [15:0] drv_vec;
  logic        drv_valid;
  logic        drv_dir;
  logic        drv_ready;

  bit_index_serializer_if #(.N(8))  b8  ();
  bit_index_serializer_if #(.N(16)) b16 ();
  bit_index_serializer_if #(.N(5))  b5  ();

  state_t st8, st16, st5;

  bit_index_serializer #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave),  .dbg_state(st8));
  bit_index_serializer #(.N(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave), .dbg_state(st16));
  bit_index_serializer #(.N(5))  u5  (.clk(clk), .rst(rst), .bus(b5.slave),  .dbg_state(st5));

  assign b8.I_VECTOR     = drv_vec[7:0];
  assign b8.I_VALID      = drv_valid && (sel == 0);
  assign b8.I_MSB_FIRST  = drv_dir;
  assign b8.I_READY      = drv_ready;
  assign b16.I_VECTOR    = drv_vec;
  assign b16.I_VALID     = drv_valid && (sel == 1);
  assign b16.I_MSB_FIRST = drv_dir;
  assign b16.I_READY     = drv_ready;
  assign b5.I_VECTOR     = drv_vec[4:0];
  assign b5.I_VALID      = drv_valid && (sel == 2);
  assign b5.I_MSB_FIRST  = drv_dir;
  assign b5.I_READY      = drv_ready;

  // Observed outputs of the selected instance.
  logic       o_valid, o_last, o_done, o_ready;
  logic [3:0] o_index;
  logic [4:0] o_count;

  always_comb begin
    o_valid = b8.O_VALID;
    o_last  = b8.O_LAST;
    o_done  = b8.O_DONE;
    o_ready = b8.O_READY;
    o_index = 4'(b8.O_INDEX);
    o_count = 5'(b8.O_COUNT);
    if (sel == 1) begin
      o_valid = b16.O_VALID;
      o_last  = b16.O_LAST;
      o_done  = b16.O_DONE;
      o_ready = b16.O_READY;
      o_index = b16.O_INDEX;
      o_count = b16.O_COUNT;
    end else if (sel == 2) begin
      o_valid = b5.O_VALID;
      o_last  = b5.O_LAST;
      o_done  = b5.O_DONE;
      o_ready = b5.O_READY;
      o_index = 4'(b5.O_INDEX);
      o_count = 5'(b5.O_COUNT);
    end
  end

  // Scoreboard state.
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic       done_exp;
  logic       hold_chk;
  logic [3:0] hold_idx;
  logic       hold_last;
  int         n_assert;
  int         n_fail;
  int         cycles;

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: indices of set bits in the requested order.
  task automatic push_expect(input logic [15:0] v, input logic d, input int n, output int k);
    int idxs[$];
    for (int j = 0; j < n; j++) begin
      int i;
      i = d ? (n - 1 - j) : j;
      if (v[i]) idxs.push_back(i);
    end
    k = idxs.size();
    for (int j = 0; j < k; j++) begin
      exp_q.push_back(8'(idxs[j]));
      exp_last_q.push_back(j == k - 1);
    end
  endtask

  // One clock cycle: sample away from the edge, score beats, record accepts.
  task automatic clk_cycle();
    logic [7:0] e;
    logic       l;
    logic       nd;
    int         k;
    #1;
    nd = 1'b0;
    chk("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
    chk("o_done", 32'(o_done), 32'(done_exp));
    if (hold_chk) begin
      chk("hold_index", 32'(o_index), 32'(hold_idx));
      chk("hold_last", 32'(o_last), 32'(hold_last));
    end
    if (o_valid && drv_ready) begin
      chk("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        l = exp_last_q.pop_front();
        chk("o_index", 32'(o_index), 32'(e));
        chk("o_last", 32'(o_last), 32'(l));
        nd = l;
      end
    end
    hold_chk  = o_valid && !drv_ready;
    hold_idx  = o_index;
    hold_last = o_last;
    if (drv_valid && o_ready) begin
      push_expect(drv_vec, drv_dir, cur_n, k);
      if (k == 0) nd = 1'b1;
    end
    done_exp = nd;
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input bit rnd, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (rnd) drv_ready = 1'($urandom_range(0, 1));
      clk_cycle();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
    drv_ready = 1'b1;
  endtask

  task automatic load(input int s, input int n, input logic [15:0] v, input logic d);
    sel       = s;
    cur_n     = n;
    drv_vec   = v;
    drv_dir   = d;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    clk_cycle();
    drv_valid = 1'b0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    sel       = 0;
    cur_n     = 8;
    drv_vec   = '0;
    drv_valid = 1'b0;
    drv_dir   = 1'b0;
    drv_ready = 1'b1;
    done_exp  = 1'b0;
    hold_chk  = 1'b0;
    hold_idx  = '0;
    hold_last = 1'b0;
    rst       = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_index", 32'(o_index), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_state8", 32'(st8), 32'(IDLE));
    chk("rst_state16", 32'(st16), 32'(IDLE));
    chk("rst_state5", 32'(st5), 32'(IDLE));
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(o_ready), 1);
    @(negedge clk);

    // 8'h8C ascending: 2, 3, 7 back to back; input changes during EMIT ignored.
    load(0, 8, 16'h008C, 1'b0);
    chk("count_8c_up", 32'(o_count), 3);
    drv_vec = 16'h00FF;
    drain(20, 1'b0, cycles);
    chk("cycles_8c_up", 32'(cycles), 3);
    clk_cycle();
    chk("state_after_8c", 32'(st8), 32'(IDLE));

    // 8'h8C descending: 7, 3, 2.
    load(0, 8, 16'h008C, 1'b1);
    chk("count_8c_dn", 32'(o_count), 3);
    drain(20, 1'b0, cycles);
    chk("cycles_8c_dn", 32'(cycles), 3);
    clk_cycle();

    // All-zero vector: no beats, done pulse, zero count.
    load(0, 8, 16'h0000, 1'b0);
    chk("count_zero", 32'(o_count), 0);
    clk_cycle();
    clk_cycle();

    // 16'hFFFF with a randomly stalling consumer.
    load(1, 16, 16'hFFFF, 1'b0);
    chk("count_ffff", 32'(o_count), 16);
    drain(400, 1'b1, cycles);
    clk_cycle();
    clk_cycle();

    // Back-to-back: 8'h81 then 8'h01 with valid held -> 0, 7, 0.
    load(0, 8, 16'h0081, 1'b0);
    chk("count_81", 32'(o_count), 2);
    drv_valid = 1'b1;
    drv_vec   = 16'h0001;
    clk_cycle();
    clk_cycle();
    drv_valid = 1'b0;
    chk("count_01", 32'(o_count), 1);
    clk_cycle();
    chk("b2b_empty", 32'(exp_q.size()), 0);
    clk_cycle();
    clk_cycle();

    // N = 5: single top bit, then a descending pattern.
    load(2, 5, 16'h0010, 1'b0);
    chk("count_5_top", 32'(o_count), 1);
    drain(10, 1'b0, cycles);
    chk("cycles_5_top", 32'(cycles), 1);
    clk_cycle();
    load(2, 5, 16'h0015, 1'b1);
    chk("count_5_15", 32'(o_count), 3);
    drain(10, 1'b0, cycles);
    chk("cycles_5_15", 32'(cycles), 3);
    clk_cycle();

    // Reset after the first beat of 8'hFF: vector abandoned, no done pulse.
    load(0, 8, 16'h00FF, 1'b0);
    clk_cycle();
    rst = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    done_exp = 1'b0;
    hold_chk = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_done", 32'(o_done), 0);
    chk("mid_rst_ready", 32'(o_ready), 0);
    chk("mid_rst_count", 32'(o_count), 0);
    chk("mid_rst_state", 32'(st8), 32'(IDLE));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(o_ready), 1);
    clk_cycle();
    clk_cycle();

    // Traffic after reset still works.
    load(0, 8, 16'h0024, 1'b1);
    drain(10, 1'b0, cycles);
    chk("cycles_after_rst", 32'(cycles), 2);
    clk_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
